// File: rtl/seq_divider_if.sv
// Start/operand and result bundle for the sequential divider.
// The master drives start and operands; the slave returns results.
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic [WIDTH-1:0] data_remainder;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_DIV,
      output data_operandA,
      output data_operandB,
      input  data_result,
      input  data_remainder,
      input  data_exception,
      input  data_resultRDY,
      input  busy
   );

   modport slave (
      input  ctrl_DIV,
      input  data_operandA,
      input  data_operandB,
      output data_result,
      output data_remainder,
      output data_exception,
      output data_resultRDY,
      output busy
   );
endinterface

// File: rtl/seq_divider.sv
// Multicycle signed divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, sign fixup on the final edge.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic         clock,
   input  logic         reset,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   bmag;
   logic [WIDTH-1:0] quo;
   logic             neg_q;
   logic             neg_r;
   logic             b_zero;
   logic             ovf;

   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] remainder;
   logic             exc;
   logic             rdy;
   logic             busy_q;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] amag;
   logic [WIDTH-1:0] bmag_w;
   logic [WIDTH:0]   sh;
   logic             ge;
   logic [WIDTH:0]   rem_n;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             last;

   assign a = bus.data_operandA;
   assign b = bus.data_operandB;

   // |-2^(W-1)| wraps to 2^(W-1), which is exact as unsigned
   assign amag   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
   assign bmag_w = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

   assign sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign ge    = {rem, quo[WIDTH-1]} >= {1'b0, bmag};
   assign rem_n = ge ? (sh - bmag) : sh;

   assign q_fix = neg_q ? (~quo + WIDTH'(1)) : quo;
   assign r_fix = neg_r ? (~rem[WIDTH-1:0] + WIDTH'(1))
                        : rem[WIDTH-1:0];
   assign last  = (cnt == CW'(WIDTH));

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         bmag      <= '0;
         quo       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         b_zero    <= 1'b0;
         ovf       <= 1'b0;
         result    <= '0;
         remainder <= '0;
         exc       <= 1'b0;
         rdy       <= 1'b0;
         busy_q    <= 1'b0;
      end else if (bus.ctrl_DIV) begin
         state  <= RUN;
         cnt    <= '0;
         rem    <= '0;
         bmag   <= {1'b0, bmag_w};
         quo    <= amag;
         neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_r  <= a[WIDTH-1];
         b_zero <= (b == '0);
         ovf    <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
         rdy    <= 1'b0;
         busy_q <= 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (last) begin
                  result    <= b_zero ? '0 : q_fix;
                  remainder <= b_zero ? '0 : r_fix;
                  exc       <= b_zero | ovf;
                  rdy       <= 1'b1;
                  busy_q    <= 1'b0;
                  state     <= DONE;
               end else begin
                  rem <= rem_n;
                  quo <= {quo[WIDTH-2:0], ge};
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               rdy   <= 1'b0;
               state <= IDLE;
            end
            default: begin
               rdy   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_result    = result;
   assign bus.data_remainder = remainder;
   assign bus.data_exception = exc;
   assign bus.data_resultRDY = rdy;
   assign bus.busy           = busy_q;
endmodule
